fir_mac_sequencer: RTL and testbench

- Time-multiplexed controller for a 9-tap FIR that drives a single multiplier and accumulator.
- Accepts one sample per transaction through a valid/ready handshake and keeps a 9-entry circular sample history.
- Runs one MAC cycle per tap, then presents the filtered result through a valid/ready output.
- Holds the coefficient set in programmable registers, so firmware can reconfigure the filter without a resynthesis.

---
 rtl/fir_mac_sequencer.sv | 126 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed 9-tap FIR controller: one multiplier, one accumulator, programmable taps.
// Define FIR_SYMMETRIC_EN to store only c[0]..c[4] and fold mirrored taps through a pre-adder.
module fir_mac_sequencer #(
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 6,
  parameter int unsigned OW   = 18,
  parameter int unsigned TAPS = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [DW-1:0] din,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [OW-1:0] dout,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic          coef_err,
  output logic          busy
);

`ifdef FIR_SYMMETRIC_EN
  localparam int unsigned NumCoef = (TAPS + 1) / 2;
  localparam int unsigned PW      = DW + 1 + CW;
`else
  localparam int unsigned NumCoef = TAPS;
  localparam int unsigned PW      = DW + CW;
`endif
  localparam int unsigned CIW     = $clog2(NumCoef);
  localparam logic [3:0]  LastTap = 4'(NumCoef - 1);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   hist_q [TAPS];
  logic [CW-1:0]   coef_q [NumCoef];
  logic [3:0]      wr_ptr_q, newest_q, tap_q;
  logic [OW-1:0]   acc_q, dout_q, acc_sum;
  logic            err_q;
  logic            accept, coef_ok;
  logic [3:0]      idx_a;
  logic [PW-1:0]   prod;

  function automatic logic [3:0] wrap_sub(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? a - b : a + 4'(TAPS) - b;
  endfunction

  function automatic logic [CW-1:0] default_coef(input int unsigned k);
    case (k)
      0, 8:    return CW'(7);
      1, 7:    return CW'(17);
      2, 6:    return CW'(32);
      3, 5:    return CW'(46);
      default: return CW'(52);
    endcase
  endfunction

  assign din_ready  = reset && (state_q == StIdle);
  assign dout_valid = (state_q == StOut);
  assign busy       = (state_q != StIdle);
  assign dout       = dout_q;
  assign coef_err   = err_q;

  assign accept  = din_valid && din_ready;
  assign coef_ok = coef_we && (state_q == StIdle) && (coef_addr < 4'(NumCoef));
  // Tap k reads the sample k positions older than the newest one
  assign idx_a   = wrap_sub(newest_q, tap_q);

`ifdef FIR_SYMMETRIC_EN
  logic [3:0]    idx_b;
  logic [DW:0]   pre;
  assign idx_b = wrap_sub(newest_q, 4'(TAPS - 1) - tap_q);
  always_comb begin
    pre = {1'b0, hist_q[idx_a]};
    if (tap_q != LastTap) pre = {1'b0, hist_q[idx_a]} + {1'b0, hist_q[idx_b]};
  end
  assign prod = PW'(coef_q[tap_q[CIW-1:0]]) * PW'(pre);
`else
  assign prod = PW'(coef_q[tap_q[CIW-1:0]]) * PW'(hist_q[idx_a]);
`endif

  assign acc_sum = acc_q + OW'(prod);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (tap_q == LastTap) state_d = StOut;
      StOut:   if (dout_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      newest_q <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) hist_q[k] <= '0;
      for (int unsigned k = 0; k < NumCoef; k++) coef_q[k] <= default_coef(k);
    end else begin
      state_q <= state_d;
      err_q   <= coef_we && !coef_ok;
      if (coef_ok) coef_q[coef_addr[CIW-1:0]] <= coef_wdata;
      if (accept) begin
        hist_q[wr_ptr_q] <= din;
        newest_q         <= wr_ptr_q;
        wr_ptr_q         <= (wr_ptr_q == 4'(TAPS - 1)) ? 4'd0 : wr_ptr_q + 4'd1;
        acc_q            <= '0;
        tap_q            <= '0;
      end
      if (state_q == StMac) begin
        acc_q <= acc_sum;
        tap_q <= tap_q + 4'd1;
        if (tap_q == LastTap) dout_q <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against a sliding-window FIR reference model.
// Honours FIR_SYMMETRIC_EN for coefficient write acceptance and latency.
module tb_fir_mac_sequencer;
  localparam int DW = 8, CW = 6, OW = 18, TAPS = 9;
`ifdef FIR_SYMMETRIC_EN
  localparam int MaxAddr = 4;
  localparam int ExpLat  = 6;
`else
  localparam int MaxAddr = 8;
  localparam int ExpLat  = 10;
`endif

  logic          clk = 1'b0, reset = 1'b0;
  logic          din_valid = 1'b0, din_ready;
  logic [DW-1:0] din = '0;
  logic          dout_valid, dout_ready = 1'b1;
  logic [OW-1:0] dout;
  logic          coef_we = 1'b0, coef_err, busy;
  logic [3:0]    coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;

  int checks = 0, failures = 0;
  int hist_m[TAPS];
  int coef_m[TAPS];
  int exp_out;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.DW(DW), .CW(CW), .OW(OW), .TAPS(TAPS)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    int defs[TAPS];
    defs = '{7, 17, 32, 46, 52, 46, 32, 17, 7};
    for (int k = 0; k < TAPS; k++) begin
      hist_m[k] = 0;
      coef_m[k] = defs[k];
    end
  endtask

  // hist_m[k] holds x[n-k]
  task automatic model_push(input int s);
    for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = s;
  endtask

  function automatic int model_out();
    int sum = 0;
    for (int k = 0; k < TAPS; k++) sum += coef_m[k] * hist_m[k];
    return sum;
  endfunction

  task automatic start_sample(input logic [DW-1:0] s);
    int w = 0;
    din = s;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    if (w >= 40) chk("din_ready_timeout", {31'd0, din_ready}, 32'd1);
    step();
    din_valid = 1'b0;
    model_push(int'(s));
    exp_out = model_out();
  endtask

  task automatic finish_sample(input string tag, output logic [OW-1:0] got, output int lat);
    int n = 1;
    while (dout_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    lat = n;
    got = dout;
    chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
    chk(tag, 32'(dout), 32'(exp_out));
    if (dout_ready) step();
  endtask

  task automatic do_sample(input logic [DW-1:0] s, input string tag, output logic [OW-1:0] got);
    int lat;
    start_sample(s);
    finish_sample(tag, got, lat);
  endtask

  task automatic coef_write(input int addr, input int data, input bit in_idle);
    bit exp_err;
    exp_err = !(in_idle && addr <= MaxAddr);
    coef_addr = 4'(addr);
    coef_wdata = CW'(data);
    coef_we = 1'b1;
    step();
    coef_we = 1'b0;
    chk("coef_err_pulse", {31'd0, coef_err}, {31'd0, exp_err});
    step();
    chk("coef_err_clear", {31'd0, coef_err}, 32'd0);
    if (!exp_err) begin
      coef_m[addr] = data;
`ifdef FIR_SYMMETRIC_EN
      coef_m[TAPS - 1 - addr] = data;
`endif
    end
  endtask

  task automatic flush();
    logic [OW-1:0] g;
    for (int i = 0; i < TAPS; i++) do_sample('0, "flush", g);
  endtask

  initial begin
    logic [OW-1:0] got, hold;
    int lat;
    int imp[10];
    logic seen;
    imp = '{1785, 4335, 8160, 11730, 13260, 11730, 8160, 4335, 1785, 0};

    reset = 1'b0;
    din_valid = 1'b1;
    repeat (3) step();
    chk("rst_din_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_coef_err", {31'd0, coef_err}, 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    din_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("idle_din_ready", {31'd0, din_ready}, 32'd1);
    model_reset();

    for (int i = 0; i < 10; i++) begin
      start_sample((i == 0) ? 8'd255 : 8'd0);
      if (i == 0) begin
        chk("mac_busy", {31'd0, busy}, 32'd1);
        chk("mac_din_ready", {31'd0, din_ready}, 32'd0);
      end
      finish_sample("impulse", got, lat);
      chk("impulse_tab", 32'(got), 32'(imp[i]));
      if (i == 0) begin
        chk("latency", 32'(lat), 32'(ExpLat));
        chk("din_ready_return", {31'd0, din_ready}, 32'd1);
      end
    end

    for (int i = 0; i < 12; i++) begin
      do_sample(8'd255, "step", got);
      if (i >= 8) chk("step_hold", 32'(got), 32'd65280);
    end

    flush();
    coef_write(4, 63, 1'b1);
    do_sample(8'd1, "c4_imp", got);
    for (int i = 0; i < 4; i++) do_sample(8'd0, "c4_imp", got);
    chk("c4_write", 32'(got), 32'd63);

    flush();
    start_sample(8'd1);
    coef_write(2, 5, 1'b0);
    finish_sample("mac_write", got, lat);
    for (int i = 0; i < 2; i++) do_sample(8'd0, "mac_write", got);
    chk("c2_unchanged", 32'(got), 32'd32);

    coef_write(12, 9, 1'b1);
    for (int i = 0; i < 3; i++) do_sample(8'($urandom_range(255)), "bad_addr", got);

    dout_ready = 1'b0;
    start_sample(8'd200);
    finish_sample("bp", hold, lat);
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1;
      din = 8'd99;
      step();
      chk("bp_valid", {31'd0, dout_valid}, 32'd1);
      chk("bp_stable", 32'(dout), 32'(hold));
      chk("bp_din_ready", {31'd0, din_ready}, 32'd0);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) do_sample(8'd0, "post_bp", got);

    start_sample(8'd77);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("abort_valid", {31'd0, dout_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= dout_valid;
    end
    chk("abort_no_result", {31'd0, seen}, 32'd0);
    do_sample(8'd255, "post_reset", got);
    chk("post_reset_first", 32'(got), 32'd1785);

    for (int i = 1; i <= 20; i++) do_sample(8'(i), "wrap", got);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) coef_write(int'($urandom_range(15)), int'($urandom_range(63)), 1'b1);
      dout_ready = 1'($urandom_range(1));
      start_sample(8'($urandom_range(255)));
      finish_sample("rand", got, lat);
      if (!dout_ready) begin
        repeat ($urandom_range(3)) step();
        chk("rand_hold", 32'(dout), 32'(exp_out));
        dout_ready = 1'b1;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
